fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined RV32 core. Sits directly upstream of decode/execute.
- Owns the PC register, issues word requests to the instruction memory/cache through a valid/ready port, and buffers one returned instruction for decode.
- Consumes the execute-stage branch/jump decision (PCSel plus ALU target) as a redirect. On a redirect it squashes wrong-path fetches, both buffered and in flight.

Parameters:
- RESET_PC, 32'h0000_2000, first fetch address after reset
- XLEN, 32, address and instruction width

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  XLEN  word-aligned fetch address
- imem_resp_valid  input  1  response data valid (exactly one per accepted request)
- imem_resp_data  input  XLEN  fetched instruction
- redirect_valid  input  1  execute-stage PCSel: taken branch/jump this cycle
- redirect_target  input  XLEN  execute-stage ALU result (new PC)
- stall_in  input  1  decode cannot accept an instruction this cycle
- inst_valid  output  1  inst_out/inst_pc hold a live instruction
- inst_out  output  XLEN  buffered instruction
- inst_pc  output  XLEN  PC of inst_out

Behaviour:
- Reset (async assert, sync release) sets these values:
  - pc_q=RESET_PC, state=S_REQ, kill_q=0
  - inst_valid=0, inst_out=32'h0000_0013 (NOP), inst_pc=RESET_PC
  - imem_req_valid=0 while reset is high
- At most one outstanding request. FSM has two states: S_REQ and S_WAIT.
- buf_free = !inst_valid || !stall_in, meaning the output buffer is empty or is being consumed this cycle.
- Consume: when inst_valid && !stall_in, inst_valid clears next cycle unless a response loads the buffer in the same cycle.
- S_REQ:
  - imem_req_valid = buf_free && !redirect_valid; imem_req_addr = pc_q.
  - On valid&&ready: req_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0), go to S_WAIT.
  - Address is held stable while valid && !ready. Valid is withdrawn only by a redirect or by the buffer becoming non-free.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with kill_q=0: inst_out<=data, inst_pc<=req_pc_q, inst_valid<=1, go to S_REQ.
  - On imem_resp_valid with kill_q=1: discard the data, kill_q<=0, go to S_REQ.
  - The buffer is guaranteed free when a response arrives, because issue requires buf_free.
- Latency: response captured in cycle N appears on inst_valid in cycle N+1. With a zero-wait memory (ready=1, resp one cycle after accept), steady-state throughput is one instruction per 2 cycles.
- Redirect (redirect_valid=1) has priority over stall_in and over any response. Same-cycle effects:
  - pc_q <= {redirect_target[XLEN-1:2],2'b00}; low two bits are ignored.
  - inst_valid <= 0 (buffered instruction is wrong-path), including when stall_in=1.
  - In S_WAIT with no response this cycle: kill_q<=1, stay in S_WAIT.
  - In S_WAIT with a response this cycle: discard it, kill_q stays 0, go to S_REQ.
  - In S_REQ: no request is issued this cycle; the fetch at the new PC is issued next cycle.
- Redirect during S_WAIT with kill_q already 1: update pc_q; kill_q stays 1. Only one response is ever outstanding.
- Reset mid-request: all state is cleared. Memory must drop any pending response on reset (system-level contract).
- imem_resp_valid outside S_WAIT is a protocol error. The bench flags it; the RTL ignores it.

Decomposition:
- Shared core package holds:
  - RESET_PC default
  - NOP encoding 32'h0000_0013
  - fetch FSM state encodings (S_REQ, S_WAIT)
  - XLEN
- Single module, no sub-module. The PC/next-PC mux and the output buffer are small enough to stay inline.

Test Plan:
- Reset release, ready=1, resp 1 cycle after accept with data 0x00500093: first req addr 0x2000, then inst_valid=1, inst_out=0x00500093, inst_pc=0x2000; next req addr 0x2004.
- Buffer full, stall_in=1 for 3 cycles: imem_req_valid=0, inst_out/inst_pc stable. In the cycle stall_in drops, the request to 0x2004 is issued.
- Request 0x2004 in flight, redirect to 0x2100 two cycles before resp: resp discarded, inst_valid stays 0, next req addr 0x2100, kill_q back to 0.
- Redirect to 0x2100 in the same cycle as imem_resp_valid: data dropped, next req 0x2100, the following response is delivered with inst_pc=0x2100.
- Buffer valid, stall_in=1, redirect target 0x2103: inst_valid=0 next cycle, next req addr 0x2100.
- Redirect to 0xFFFF_FFFC, fetch completes: inst_pc=0xFFFF_FFFC, following req addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants for the instruction-fetch stage
package fetch_unit_pkg;

    localparam int          CORE_XLEN     = 32;
    localparam logic [31:0] CORE_RESET_PC = 32'h0000_2000;
    localparam logic [31:0] NOP_INSN      = 32'h0000_0013;

    localparam logic [0:0]  S_REQ  = 1'b0;
    localparam logic [0:0]  S_WAIT = 1'b1;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 fetch stage: PC, single-outstanding imem port, one-entry decode buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CORE_RESET_PC,
    parameter int          XLEN     = CORE_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall_in,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc
);

    logic [0:0]      state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            kill_q;

    logic buf_free;
    logic req_fire;
    logic resp_hit;
    logic unused_target_lsbs;

    // Redirect targets are word-aligned by dropping the low bits.
    assign unused_target_lsbs = ^redirect_target[1:0];

    assign buf_free       = !inst_valid || !stall_in;
    assign imem_req_valid = !reset && (state == S_REQ) && buf_free && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_hit       = (state == S_WAIT) && imem_resp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pc_q       <= XLEN'(RESET_PC);
            req_pc_q   <= XLEN'(RESET_PC);
            kill_q     <= 1'b0;
            inst_valid <= 1'b0;
            inst_out   <= XLEN'(NOP_INSN);
            inst_pc    <= XLEN'(RESET_PC);
        end else if (redirect_valid) begin
            // The buffered instruction and any in-flight fetch are wrong-path.
            pc_q       <= {redirect_target[XLEN-1:2], 2'b00};
            inst_valid <= 1'b0;
            if (state == S_WAIT) begin
                if (resp_hit) begin
                    kill_q <= 1'b0;
                    state  <= S_REQ;
                end else begin
                    kill_q <= 1'b1;
                end
            end
        end else begin
            if (inst_valid && !stall_in) begin
                inst_valid <= 1'b0;
            end
            if (state == S_REQ) begin
                if (req_fire) begin
                    req_pc_q <= pc_q;
                    pc_q     <= pc_q + XLEN'(4);
                    state    <= S_WAIT;
                end
            end else if (resp_hit) begin
                if (!kill_q) begin
                    inst_out   <= imem_resp_data;
                    inst_pc    <= req_pc_q;
                    inst_valid <= 1'b1;
                end
                kill_q <= 1'b0;
                state  <= S_REQ;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall_in;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    int passed = 0;
    int total  = 0;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall_in        (stall_in),
        .inst_valid      (inst_valid),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        stall_in        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        total++;
        if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b want 0", imem_req_valid);
        else passed++;
        total++;
        if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %b want 0", inst_valid);
        else passed++;
        total++;
        if (inst_out !== 32'h0000_0013) $display("FAIL reset_inst_out got %h want 00000013", inst_out);
        else passed++;
        total++;
        if (inst_pc !== 32'h0000_2000) $display("FAIL reset_inst_pc got %h want 00002000", inst_pc);
        else passed++;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000)
            $display("FAIL first_req got v=%b a=%h want v=1 a=00002000", imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    // Accept the request presented now and answer it next cycle with data.
    task automatic fetch_now(input logic [31:0] data);
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        cycle();
        imem_resp_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        fetch_now(32'h0050_0093);
        imem_req_ready = 1'b1;
        #1;
        total++;
        if (inst_valid !== 1'b1 || inst_out !== 32'h0050_0093 || inst_pc !== 32'h2000)
            $display("FAIL basic_inst got v=%b d=%h pc=%h want v=1 d=00500093 pc=00002000",
                     inst_valid, inst_out, inst_pc);
        else passed++;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2004)
            $display("FAIL basic_next_req got v=%b a=%h want v=1 a=00002004", imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        fetch_now(32'h1111_2222);
        stall_in = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_out !== 32'h1111_2222 ||
                inst_pc !== 32'h2000)
                $display("FAIL stall_hold[%0d] got rv=%b iv=%b d=%h pc=%h want rv=0 iv=1 d=11112222 pc=00002000",
                         i, imem_req_valid, inst_valid, inst_out, inst_pc);
            else passed++;
            cycle();
        end
        stall_in = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2004)
            $display("FAIL stall_release got v=%b a=%h want v=1 a=00002004", imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    // Gets request 0x2004 in flight with an empty buffer.
    task automatic start_second_fetch();
        do_reset();
        fetch_now(32'hAAAA_0001);
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
    endtask

    task automatic test_redirect_inflight();
        start_second_fetch();
        redirect_valid  = 1'b1;
        redirect_target = 32'h2100;
        cycle();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (dut.kill_q !== 1'b1) $display("FAIL inflight_kill_set got %b want 1", dut.kill_q);
        else passed++;
        cycle();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        cycle();
        imem_resp_valid = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0) $display("FAIL inflight_discard got %b want 0", inst_valid);
        else passed++;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2100 || dut.kill_q !== 1'b0)
            $display("FAIL inflight_next_req got v=%b a=%h k=%b want v=1 a=00002100 k=0",
                     imem_req_valid, imem_req_addr, dut.kill_q);
        else passed++;
    endtask

    task automatic test_redirect_with_resp();
        start_second_fetch();
        redirect_valid  = 1'b1;
        redirect_target = 32'h2100;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        cycle();
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0 || dut.kill_q !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2100)
            $display("FAIL samecycle_drop got iv=%b k=%b rv=%b a=%h want iv=0 k=0 rv=1 a=00002100",
                     inst_valid, dut.kill_q, imem_req_valid, imem_req_addr);
        else passed++;
        fetch_now(32'h0012_3456);
        #1;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h2100 || inst_out !== 32'h0012_3456)
            $display("FAIL samecycle_next got v=%b pc=%h d=%h want v=1 pc=00002100 d=00123456",
                     inst_valid, inst_pc, inst_out);
        else passed++;
    endtask

    task automatic test_redirect_stall();
        do_reset();
        fetch_now(32'h5555_0000);
        stall_in        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h2103;
        cycle();
        redirect_valid = 1'b0;
        stall_in       = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0) $display("FAIL stall_redirect_flush got %b want 0", inst_valid);
        else passed++;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2100)
            $display("FAIL stall_redirect_req got v=%b a=%h want v=1 a=00002100", imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        #1;
        total++;
        if (imem_req_valid !== 1'b0) $display("FAIL wrap_redirect_blocks got %b want 0", imem_req_valid);
        else passed++;
        cycle();
        redirect_valid = 1'b0;
        fetch_now(32'h0BAD_F00D);
        stall_in = 1'b1;
        #1;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_pc got v=%b pc=%h want v=1 pc=fffffffc", inst_valid, inst_pc);
        else passed++;
        stall_in = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL wrap_next_req got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    // Random traffic: decode must see the architectural stream (sequential words,
    // restarting at each redirect target) and memory must see matching addresses.
    task automatic test_random();
        logic [31:0] exp_pc, exp_req, pend_addr, held_addr;
        logic        pending, outstanding, held;
        int          countdown, delivered, errs;
        do_reset();
        exp_pc      = 32'h2000;
        exp_req     = 32'h2000;
        pending     = 1'b0;
        outstanding = 1'b0;
        held        = 1'b0;
        held_addr   = 32'h0;
        pend_addr   = 32'h0;
        countdown   = 0;
        delivered   = 0;
        errs        = 0;
        for (int c = 0; c < 3000; c++) begin
            redirect_valid  = ($urandom_range(0, 15) == 0);
            redirect_target = $urandom_range(0, 32'h0000_3FFF) | 32'h0000_2000;
            stall_in        = ($urandom_range(0, 3) == 0);
            imem_req_ready  = ($urandom_range(0, 2) != 0);
            imem_resp_valid = 1'b0;
            if (pending) begin
                if (countdown == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend_addr);
                    pending         = 1'b0;
                end else begin
                    countdown--;
                end
            end
            #1;
            if (imem_req_valid && outstanding) begin
                errs++;
                if (errs < 5) $display("FAIL rand_two_outstanding at cycle %0d", c);
            end
            if (imem_req_valid && held && imem_req_addr !== held_addr) begin
                errs++;
                if (errs < 5) $display("FAIL rand_addr_unstable got %h want %h", imem_req_addr, held_addr);
            end
            held      = imem_req_valid && !imem_req_ready;
            held_addr = imem_req_addr;
            if (imem_req_valid && imem_req_ready) begin
                if (imem_req_addr !== exp_req) begin
                    errs++;
                    if (errs < 5) $display("FAIL rand_req_addr got %h want %h", imem_req_addr, exp_req);
                end
                exp_req     = exp_req + 32'd4;
                pend_addr   = imem_req_addr;
                pending     = 1'b1;
                outstanding = 1'b1;
                countdown   = $urandom_range(0, 3);
            end
            if (imem_resp_valid) outstanding = 1'b0;
            if (inst_valid && !stall_in && !redirect_valid) begin
                if (inst_pc !== exp_pc || inst_out !== mem_word(exp_pc)) begin
                    errs++;
                    if (errs < 5) $display("FAIL rand_deliver got pc=%h d=%h want pc=%h d=%h",
                                           inst_pc, inst_out, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) begin
                exp_pc  = redirect_target & 32'hFFFF_FFFC;
                exp_req = exp_pc;
                held    = 1'b0;
            end
            cycle();
        end
        idle_inputs();
        total++;
        if (errs != 0) $display("FAIL rand_stream got %0d errors want 0", errs);
        else passed++;
        total++;
        if (delivered < 100) $display("FAIL rand_progress got %0d delivered want >=100", delivered);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_inflight();
        test_redirect_with_resp();
        test_redirect_stall();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
